// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
//
// Multi-cycle add/subtract unit. A DATA_SIZE-bit operand pair is processed
// CHUNK_SIZE bits per clock, and the carry ripples between cycles through a
// register. A start/ready/done handshake frames each operation. The carry,
// signed-overflow and zero flags are registered alongside the result. The
// carry flag doubles as the stored carry consumed by ADC/SBB, which lets the
// sequencer chain several words into one multi-word operation.
//
// Parameters
//   DATA_SIZE   operand/result width in bits
//   CHUNK_SIZE  bits processed per cycle (must divide DATA_SIZE exactly)
//
// Ports
//   clk_in        clock, all logic on the rising edge
//   rst_in        synchronous active-high reset
//   start_in      request, accepted only while ready_out is high
//   a_in, b_in    operands, captured on accept
//   mode_in       00 ADD, 01 SUB, 10 ADC, 11 SBB, captured on accept
//   ready_out     high while idle
//   done_out      one-cycle pulse when result/flags have just been updated
//   result_out    result, held until the next done
//   carry_out     carry out of the MSB (for SUB/SBB, 1 = no borrow)
//   overflow_out  signed two's-complement overflow
//   zero_out      result_out == 0
// -----------------------------------------------------------------------------
module add_sub_seq #(
    parameter int DATA_SIZE  = 16,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [DATA_SIZE-1:0] a_in,
    input  logic [DATA_SIZE-1:0] b_in,
    input  logic [1:0]           mode_in,
    output logic                 ready_out,
    output logic                 done_out,
    output logic [DATA_SIZE-1:0] result_out,
    output logic                 carry_out,
    output logic                 overflow_out,
    output logic                 zero_out
);

    localparam int NUM_CHUNKS = DATA_SIZE / CHUNK_SIZE;
    // The index counts up to NUM_CHUNKS inclusive. The extra value marks
    // "all chunks consumed" and gives the cycle in which the flags are registered.
    localparam int IDX_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [IDX_W-1:0] ALL_CHUNKS = IDX_W'(NUM_CHUNKS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Control and architectural state (reset)
    logic [1:0]           state_q,  state_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
    logic                 carry_q,  carry_d;   // carry flag and stored carry
    logic                 ovf_q,    ovf_d;
    logic                 zero_q,   zero_d;

    // Datapath working registers (not reset)
    logic [DATA_SIZE-1:0] a_q,   a_d;    // shifts right one chunk per cycle
    logic [DATA_SIZE-1:0] b_q,   b_d;    // holds B' (already inverted for SUB/SBB)
    logic [DATA_SIZE-1:0] sum_q, sum_d;  // chunks enter at the top and shift down
    logic                 cy_q,  cy_d;   // ripple carry between chunks
    logic                 vf_q,  vf_d;   // overflow of the most recent chunk

    // Per-chunk adder
    logic [CHUNK_SIZE-1:0]           chunk_a;
    logic [CHUNK_SIZE-1:0]           chunk_b;
    logic [CHUNK_SIZE:0]             chunk_sum;
    logic                            msb_cin;
    logic [DATA_SIZE+CHUNK_SIZE-1:0] sum_ins;

    always_comb begin
        chunk_a   = a_q[CHUNK_SIZE-1:0];
        chunk_b   = b_q[CHUNK_SIZE-1:0];
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK_SIZE{1'b0}}, cy_q};
        // Carry into the chunk's top bit. Only the value from the last chunk
        // (the true operand MSB) survives into the overflow flag.
        msb_cin   = chunk_a[CHUNK_SIZE-1] ^ chunk_b[CHUNK_SIZE-1] ^ chunk_sum[CHUNK_SIZE-1];
        // The new chunk goes in at the top and everything shifts down one
        // chunk. After NUM_CHUNKS steps the first chunk sits at bit 0.
        sum_ins   = {chunk_sum[CHUNK_SIZE-1:0], sum_q} >> CHUNK_SIZE;
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cy_d     = cy_q;
        vf_d     = vf_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    // mode bit 0 selects subtraction, mode bit 1 selects stored-carry cin
                    b_d     = mode_in[0] ? ~b_in : b_in;
                    cy_d    = mode_in[1] ? carry_q : mode_in[0];
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (idx_q == ALL_CHUNKS) begin
                    result_d = sum_q;
                    carry_d  = cy_q;
                    ovf_d    = vf_q;
                    zero_d   = (sum_q == '0);
                    state_d  = DONE;
                end else begin
                    a_d   = a_q >> CHUNK_SIZE;
                    b_d   = b_q >> CHUNK_SIZE;
                    sum_d = sum_ins[DATA_SIZE-1:0];
                    cy_d  = chunk_sum[CHUNK_SIZE];
                    vf_d  = msb_cin ^ chunk_sum[CHUNK_SIZE];
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // NOTE: the working datapath registers are always written before they are
    // read in an operation, so they carry no reset.
    always_ff @(posedge clk_in) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sum_q <= sum_d;
        cy_q  <= cy_d;
        vf_q  <= vf_d;
    end

    assign ready_out    = (state_q == IDLE);
    assign done_out     = (state_q == DONE);
    assign result_out   = result_q;
    assign carry_out    = carry_q;
    assign overflow_out = ovf_q;
    assign zero_out     = zero_q;

endmodule
